codeword_channel_injector: RTL

//   Pipelined channel-model stage between the 4->15 encoder and the XOR/decoder stages.

---
 rtl/codeword_channel_injector_if.sv | 34 +++
 rtl/codeword_channel_injector.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/codeword_channel_injector_if.sv
// Codeword stream bundle for the channel injector.
// Carries the upstream (encoder -> injector) and downstream
// (injector -> XOR/decoder) valid/ready handshakes plus data.
// slave  : the injector's view (consumes in_*, produces out_*)
// master : the surrounding logic's view (produces in_*, consumes out_*)
interface codeword_channel_injector_if;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] in_cw;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_cw;
  logic [14:0] out_err;

  modport slave (
    input  in_valid,
    input  in_cw,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_cw,
    output out_err
  );

  modport master (
    output in_valid,
    output in_cw,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_cw,
    input  out_err
  );
endinterface

// File: rtl/codeword_channel_injector.sv
// codeword_channel_injector
//   Single-register channel-model stage for 15-bit codewords. Each
//   accepted word is XORed with an error pattern chosen by cfg_mode
//   (none / fixed bit / LFSR-chosen bit / periodic fixed bit), and the
//   corrupted word is presented together with the pattern so a checker
//   can predict the decoder's output. Saturating counters track
//   accepted words and accepted words that carried a nonzero pattern.
//
//   Optional feature macro: INJ_DOUBLE_ERR_EN
//     When defined, adds input cfg_dbl_i. With cfg_dbl_i=1 and a
//     nonzero base pattern at position p, bit (p+1) mod 15 is also set.
//     When undefined, out_err never has more than one bit set.
module codeword_channel_injector #(
  parameter int          CW_W      = 15,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             cfg_mode_i,
  input  logic [3:0]             cfg_pos_i,
  input  logic [7:0]             cfg_period_i,
`ifdef INJ_DOUBLE_ERR_EN
  input  logic                   cfg_dbl_i,
`endif
  codeword_channel_injector_if.slave stream,
  output logic [CNT_W-1:0]       word_cnt_o,
  output logic [CNT_W-1:0]       err_cnt_o
);

  localparam logic [1:0] MODE_NONE     = 2'b00;
  localparam logic [1:0] MODE_FIXED    = 2'b01;
  localparam logic [1:0] MODE_LFSR     = 2'b10;
  localparam logic [1:0] MODE_PERIODIC = 2'b11;

  // Position 15 does not exist in a 15-bit word; it doubles as "no bit".
  localparam logic [3:0] POS_NONE = 4'd15;

  // ---------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------
  logic              out_valid_q, out_valid_d;
  logic [CW_W-1:0]   out_cw_q,    out_cw_d;
  logic [CW_W-1:0]   out_err_q,   out_err_d;
  logic [15:0]       lfsr_q,      lfsr_d;
  logic [7:0]        per_cnt_q,   per_cnt_d;
  logic [CNT_W-1:0]  word_cnt_q,  word_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q,   err_cnt_d;

  // ---------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------
  logic accept;
  logic in_ready;

  // A held word only blocks the input while downstream is stalling.
  assign in_ready = !out_valid_q || stream.out_ready;
  assign accept   = stream.in_valid && in_ready;

  // ---------------------------------------------------------------
  // Pattern generation (pure function of config + current state)
  // ---------------------------------------------------------------
  logic [8:0]      per_eff;
  logic [8:0]      per_next;
  logic            per_hit;
  logic [3:0]      lfsr_pos;
  logic            base_en;
  logic [3:0]      base_pos;
  logic [3:0]      dbl_pos;
  logic            dbl_en;
  logic [CW_W-1:0] base_err;
  logic [CW_W-1:0] dbl_err;
  logic [CW_W-1:0] err_pat;
  logic            lfsr_fb;

  // A programmed period of 0 behaves like a period of 1 (every word).
  assign per_eff  = (cfg_period_i == 8'd0) ? 9'd1 : {1'b0, cfg_period_i};
  assign per_next = {1'b0, per_cnt_q} + 9'd1;
  assign per_hit  = (per_next == per_eff);

  // Nibble value 15 would fall off the codeword, so fold it onto bit 0.
  assign lfsr_pos = (lfsr_q[3:0] == 4'hF) ? 4'd0 : lfsr_q[3:0];

  // Select the base error position and whether a bit is injected at all.
  always_comb begin
    base_en  = 1'b0;
    base_pos = 4'd0;
    case (cfg_mode_i)
      MODE_NONE: begin
        base_en  = 1'b0;
        base_pos = 4'd0;
      end
      MODE_FIXED: begin
        base_en  = (cfg_pos_i != POS_NONE);
        base_pos = cfg_pos_i;
      end
      MODE_LFSR: begin
        base_en  = 1'b1;
        base_pos = lfsr_pos;
      end
      MODE_PERIODIC: begin
        base_en  = per_hit && (cfg_pos_i != POS_NONE);
        base_pos = cfg_pos_i;
      end
      default: begin
        base_en  = 1'b0;
        base_pos = 4'd0;
      end
    endcase
  end

  // Neighbouring bit for the double-error option, wrapping 14 -> 0.
  assign dbl_pos = (base_pos == 4'd14) ? 4'd0 : (base_pos + 4'd1);

`ifdef INJ_DOUBLE_ERR_EN
  assign dbl_en = base_en && cfg_dbl_i;
`else
  assign dbl_en = 1'b0;
`endif

  // One-hot decode of the base and neighbour positions.
  generate
    for (genvar gi = 0; gi < CW_W; gi++) begin : g_decode
      assign base_err[gi] = base_en && (base_pos == 4'(gi));
      assign dbl_err[gi]  = dbl_en  && (dbl_pos  == 4'(gi));
    end
  endgenerate

  assign err_pat = base_err | dbl_err;

  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10 of the shift register.
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // ---------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------

  // Output register: load on accept, drop valid on a drain with no refill,
  // otherwise hold everything so a stalled word stays stable.
  always_comb begin
    out_valid_d = out_valid_q;
    out_cw_d    = out_cw_q;
    out_err_d   = out_err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_cw_d    = stream.in_cw ^ err_pat;
      out_err_d   = err_pat;
    end else if (stream.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // LFSR steps once per accepted word regardless of mode.
  always_comb begin
    lfsr_d = lfsr_q;
    if (accept) begin
      lfsr_d = {lfsr_q[14:0], lfsr_fb};
    end
  end

  // Period counter only lives in periodic mode; any other mode clears it.
  always_comb begin
    per_cnt_d = per_cnt_q;
    if (cfg_mode_i != MODE_PERIODIC) begin
      per_cnt_d = 8'd0;
    end else if (accept) begin
      per_cnt_d = per_hit ? 8'd0 : per_next[7:0];
    end
  end

  // Saturating statistics: one word per accept, one error per corrupted word.
  always_comb begin
    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (accept) begin
      if (word_cnt_q != {CNT_W{1'b1}}) begin
        word_cnt_d = word_cnt_q + 1'b1;
      end
      if ((err_pat != '0) && (err_cnt_q != {CNT_W{1'b1}})) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------

  // Pipeline output register; reset discards any held word.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_cw_q    <= '0;
      out_err_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_cw_q    <= out_cw_d;
      out_err_q   <= out_err_d;
    end
  end

  // Pattern-generator state: position LFSR and period counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q    <= LFSR_SEED;
      per_cnt_q <= 8'd0;
    end else begin
      lfsr_q    <= lfsr_d;
      per_cnt_q <= per_cnt_d;
    end
  end

  // Statistics counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // ---------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------
  assign stream.in_ready  = in_ready;
  assign stream.out_valid = out_valid_q;
  assign stream.out_cw    = out_cw_q;
  assign stream.out_err   = out_err_q;
  assign word_cnt_o       = word_cnt_q;
  assign err_cnt_o        = err_cnt_q;

endmodule
